// File: rtl/sort_pkg.sv
// Shared types and helpers for the 16-key bitonic sorter: key/vector types,
// MSB-first bus packing, and the per-stage (k, j) schedule of the network.
package sort_pkg;
  localparam int KEY_W      = 32;
  localparam int NUM_KEYS   = 16;
  localparam int NUM_STAGES = 10;
  localparam int LATENCY    = 12;

  typedef logic [KEY_W-1:0]        key_t;
  typedef key_t [NUM_KEYS-1:0]     key_vec_t;

  // Key 0 lives in the most significant slice of the bus.
  function automatic key_vec_t unpack_keys(input logic [NUM_KEYS*KEY_W-1:0] bus);
    key_vec_t v;
    for (int k = 0; k < NUM_KEYS; k++)
      v[k] = bus[(NUM_KEYS-k)*KEY_W-1 -: KEY_W];
    return v;
  endfunction

  function automatic logic [NUM_KEYS*KEY_W-1:0] pack_keys(input key_vec_t v);
    logic [NUM_KEYS*KEY_W-1:0] bus;
    bus = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      bus[(NUM_KEYS-k)*KEY_W-1 -: KEY_W] = v[k];
    return bus;
  endfunction

  function automatic int stage_k(input int s);
    case (s)
      0:       return 2;
      1, 2:    return 4;
      3, 4, 5: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int stage_j(input int s);
    case (s)
      0, 2, 5, 9: return 1;
      1, 4, 8:    return 2;
      3, 7:       return 4;
      default:    return 8;
    endcase
  endfunction
endpackage

// File: rtl/bitonic_sorting_network_compare_exchange.sv
// Combinational unsigned compare-exchange: lo = min(a, b), hi = max(a, b).
module compare_exchange #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);
  logic a_lt_b;
  assign a_lt_b = a < b;
  assign lo = a_lt_b ? a : b;
  assign hi = a_lt_b ? b : a;
endmodule

// File: rtl/bitonic_sorting_network.sv
// 16-key bitonic sorter: capture rank, 10 compare-exchange ranks, output rank.
// The whole pipeline advances together on ena; nothing moves while it is low.
module bitonic_sorting_network
  import sort_pkg::*;
#(
  parameter int DATA_W = KEY_W,
  parameter int N      = NUM_KEYS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [N*DATA_W-1:0] data_in,
  output logic [N*DATA_W-1:0] data_out,
  output logic                valid
);
  localparam int STAGES = LATENCY - 1;

  key_vec_t         rank      [LATENCY];
  key_vec_t         stage_out [NUM_STAGES];
  logic [STAGES:0]  vld_pipe;

  // Stage s reads rank s and feeds rank s+1.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int K = stage_k(s);
    localparam int J = stage_j(s);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      localparam int P = i ^ J;
      if (P > i) begin : g_cx
        logic [DATA_W-1:0] lo, hi;
        compare_exchange #(.DATA_W(DATA_W)) u_cx (
          .a (rank[s][i]),
          .b (rank[s][P]),
          .lo(lo),
          .hi(hi)
        );
        // Direction flips with bit k of the lower index to build bitonic runs.
        assign stage_out[s][i] = ((i & K) == 0) ? lo : hi;
        assign stage_out[s][P] = ((i & K) == 0) ? hi : lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < LATENCY; r++) rank[r] <= '0;
      vld_pipe <= '0;
    end else if (ena) begin
      rank[0] <= unpack_keys(data_in);
      for (int s = 0; s < NUM_STAGES; s++) rank[s+1] <= stage_out[s];
      rank[STAGES] <= rank[STAGES-1];
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  assign data_out = pack_keys(rank[STAGES]);
  assign valid    = vld_pipe[STAGES];
endmodule

// File: tb/tb_bitonic_sorting_network.sv
// Scoreboard bench: the driver pushes the reference-sorted vector at each
// enabled capture; the monitor pops and compares whenever a new output lands.
module tb_bitonic_sorting_network;
  localparam int KW = 32;
  localparam int NK = 16;
  localparam int BW = KW * NK;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic [BW-1:0] data_in = '0;
  logic [BW-1:0] data_out;
  logic          valid;

  int compared   = 0;
  int mismatched = 0;

  logic [BW-1:0] exp_q [$];
  int            n_en = 0;
  logic [BW-1:0] last_out = '0;
  logic          last_valid = 1'b0;

  bitonic_sorting_network dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .data_in (data_in),
    .data_out(data_out),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: unpack keys, plain selection sort ascending, repack key 0 at MSB.
  function automatic logic [BW-1:0] ref_sort(input logic [BW-1:0] v);
    logic [KW-1:0] a [NK];
    logic [KW-1:0] t;
    logic [BW-1:0] r;
    for (int k = 0; k < NK; k++) a[k] = v[BW-1-KW*k -: KW];
    for (int x = 0; x < NK; x++)
      for (int y = x + 1; y < NK; y++)
        if (a[y] < a[x]) begin t = a[x]; a[x] = a[y]; a[y] = t; end
    r = '0;
    for (int k = 0; k < NK; k++) r[BW-1-KW*k -: KW] = a[k];
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_vec(input bit narrow);
    logic [BW-1:0] v;
    for (int k = 0; k < NK; k++)
      v[BW-1-KW*k -: KW] = narrow ? KW'($urandom_range(0, 7)) : KW'($urandom);
    return v;
  endfunction

  // Monitor / scoreboard.
  always @(posedge clk) begin
    logic r_s, e_s;
    r_s = rst;
    e_s = ena;
    if (r_s) begin
      exp_q.delete();
      n_en = 0;
    end else if (e_s) begin
      exp_q.push_back(ref_sort(data_in));
      n_en++;
    end
    #1;
    if (r_s) begin
      chk("reset_valid", BW'(valid), BW'(1'b0));
      chk("reset_data", data_out, '0);
    end else if (e_s) begin
      chk("valid_timing", BW'(valid), BW'(n_en >= 12));
      if (valid) begin
        if (exp_q.size() == 0) chk("queue_underflow", data_out, ~data_out);
        else chk("sorted_data", data_out, exp_q.pop_front());
      end else begin
        chk("idle_data_zero", data_out, '0);
      end
    end else begin
      chk("stall_valid", BW'(valid), BW'(last_valid));
      chk("stall_data", data_out, last_out);
    end
    last_out   = data_out;
    last_valid = valid;
  end

  task automatic drive(input logic r, input logic e, input logic [BW-1:0] d);
    @(negedge clk);
    rst = r; ena = e; data_in = d;
  endtask

  initial begin
    logic [BW-1:0] v;
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, rand_vec(1'b0));
    // Reversed keys, then duplicates/extremes.
    for (int k = 0; k < NK; k++) v[BW-1-KW*k -: KW] = KW'(15 - k);
    drive(1'b0, 1'b1, v);
    v = {32'hFFFFFFFF, 32'h0, 32'h7, 32'h7, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h7,
         32'h0, 32'hDEADBEEF, 32'h7FFFFFFF, 32'h80000001, 32'h2, 32'h0, 32'h1, 32'h7};
    drive(1'b0, 1'b1, v);
    // Back-to-back random, some with many duplicates.
    for (int n = 0; n < 20; n++) drive(1'b0, 1'b1, rand_vec(n % 4 == 3));
    // Already sorted and all-equal.
    for (int k = 0; k < NK; k++) v[BW-1-KW*k -: KW] = KW'(k * 1000 + 3);
    drive(1'b0, 1'b1, v);
    v = {NK{32'h0000_1234}};
    drive(1'b0, 1'b1, v);
    for (int n = 0; n < 12; n++) drive(1'b0, 1'b1, rand_vec(1'b0));
    // Stall: 5 enabled, 7 held, then drain.
    drive(1'b1, 1'b0, '0);
    for (int n = 0; n < 5; n++) drive(1'b0, 1'b1, rand_vec(1'b0));
    for (int n = 0; n < 7; n++) drive(1'b0, 1'b0, rand_vec(1'b0));
    for (int n = 0; n < 10; n++) drive(1'b0, 1'b1, rand_vec(1'b0));
    for (int n = 0; n < 7; n++) drive(1'b0, 1'b0, rand_vec(1'b0));
    for (int n = 0; n < 4; n++) drive(1'b0, 1'b1, rand_vec(1'b1));
    // Reset mid-flight with ena high.
    for (int n = 0; n < 6; n++) drive(1'b0, 1'b1, rand_vec(1'b0));
    drive(1'b1, 1'b1, rand_vec(1'b0));
    for (int n = 0; n < 14; n++) drive(1'b0, 1'b1, rand_vec(1'b0));
    // Random ena toggling.
    for (int n = 0; n < 60; n++) drive(1'b0, 1'($urandom_range(0, 1)), rand_vec(n % 3 == 0));
    for (int n = 0; n < 14; n++) drive(1'b0, 1'b1, rand_vec(1'b0));
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bitonic_sorting_network.md
Name: bitonic_sorting_network

Overview:
- Fully pipelined 16-input, 32-bit sorting network. Sorts one 512-bit vector of 16 unsigned keys per enabled clock, with fixed latency.
- Front end of the hardware sorter. Each sorted 16-key block feeds the per-way input modules, which serialize it into the 8-way merge sorter tree.

Parameters:
- DATA_W, 32, key width in bits. Unsigned compare.
- N, 16, number of keys. Fixed; the network topology below is defined for 16 only.
- LATENCY, 12, enabled cycles from capture to data_out (localparam, informational).

Ports:
- clk, input, 1, rising-edge clock. This is the only clock.
- rst, input, 1, reset. Synchronous, active-high.
- ena, input, 1, pipeline advance enable. 0 stalls the whole pipeline.
- data_in, input, 512, 16 keys. Key k occupies bits [511-32k -: 32]; key 0 is in the MSB slice.
- data_out, output, 512, sorted keys, same packing as data_in.
- valid, output, 1, 1 when data_out holds a sorted vector.

Behaviour:
- All state is registered on the rising edge of clk.
- Priority: rst, then ena, then hold.
- Reset (rst=1 at an edge):
  - Clears every stage register, every stage valid bit, data_out and valid to 0.
  - This happens regardless of ena.
  - A reset mid-operation discards all in-flight vectors.
- Pipeline has 12 register ranks:
  - Rank 0 captures data_in.
  - Ranks 1..10 are comparator stages.
  - Rank 11 is the data_out register.
  - Each rank carries a valid bit. Rank 0 loads valid bit 1 whenever ena=1.
- ena=1 edge: every rank loads from its predecessor; rank 0 loads data_in and a valid bit of 1.
- ena=0 edge: every rank, data_out and valid hold. There are no bubbles and no data loss.
- Latency: the vector captured at an enabled edge appears on data_out after the 11th subsequent enabled edge, i.e. 12 enabled edges inclusive. valid is the valid bit of rank 11.
- Throughput: one vector per enabled cycle. data_in may change every cycle.
- With ena held high after reset, valid rises after the 12th edge and stays high.
- Order: ascending unsigned. Key 0 (MSB slice) is the minimum; key 15 (LSB slice) is the maximum.
  - Equal keys are permitted; the output is the multiset sorted.
  - 32'hFFFFFFFF sorts above 0.
- Network: bitonic sort, 10 stages.
  - Stages in order: (k=2, j=1), (k=4, j=2), (k=4, j=1), (k=8, j=4), (k=8, j=2), (k=8, j=1), (k=16, j=8), (k=16, j=4), (k=16, j=2), (k=16, j=1).
  - Within a stage, for index i with partner p = i XOR j and p > i:
    - if (i AND k) == 0, position i gets the min and p gets the max;
    - otherwise position i gets the max and p gets the min.
  - Indices are logical key numbers 0..15.
- Each comparator stage is purely combinational, one compare-exchange level, followed by its rank register.
- No X propagation: every output is driven from reset onward.

Decomposition:
- Shared package sort_pkg:
  - KEY_W = 32, NUM_KEYS = 16;
  - key_t typedef (logic [31:0]);
  - key_vec_t (array of 16 key_t);
  - pack/unpack functions between key_vec_t and the 512-bit bus, using the MSB-first key order.
- One sub-module, compare_exchange: a combinational 2-input min/max for DATA_W unsigned keys, with output lo = min and hi = max.
- The top-level instantiates stages with generate loops. No further hierarchy.

Test Plan:
- Reset then ena=1; data_in = keys 15,14,...,0 (key 0 = 15) -> after the 12th enabled edge: valid=1 and data_out = keys 0,1,...,15. Before that edge valid=0 and data_out=0.
- Duplicates and extremes: keys {FFFFFFFF, 0, 7, 7, 80000000, 1, ...} -> ascending unsigned with both 7s retained, 0 at key 0, FFFFFFFF at key 15.
- Back-to-back: 20 random vectors on consecutive enabled cycles -> 20 consecutive sorted outputs, each 12 edges after its capture. Check against a reference sort.
- Stall: after 5 enabled edges deassert ena for 7 cycles -> data_out and valid frozen throughout the stall. Sorted output appears after 7 more enabled edges.
- Reset mid-flight: after 6 enabled edges assert rst with ena=1 -> valid=0 and data_out=0 at the next edge. The next valid appears 12 enabled edges after rst is released.
- Already-sorted and all-equal (all 32'h0000_1234) inputs -> output identical to input.
